// File: rtl/cim_job_seq.sv
// CIM job sequencer: issues one instruction to the RCOC, then waits for completion, timeout or abort.
// It also arbitrates the CIM array ports between the host and the running job.
module cim_job_seq #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     inst_cfg,
    input  logic [TO_W-1:0] timeout_cfg,
    input  logic            abort,
    output logic [31:0]     inst,
    output logic            inst_vld,
    input  logic            inst_rdy,
    input  logic            irq,
    input  logic            host_req,
    output logic            host_gnt,
    output logic            busy,
    output logic            done,
    output logic [3:0]      status,
    output logic [31:0]     cyc_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [31:0]     r_inst;
    logic            r_inst_vld;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_status;
    logic [31:0]     r_cyc;
    logic [TO_W-1:0] r_to;
    logic [TO_W-1:0] r_run_cnt;

    logic [TO_W-1:0] w_run_nxt;
    logic [31:0]     w_cyc_nxt;
    logic            w_expire;

    // Both counters saturate instead of wrapping.
    assign w_run_nxt = (&r_run_cnt) ? r_run_cnt : r_run_cnt + TO_W'(1);
    assign w_cyc_nxt = (&r_cyc) ? r_cyc : r_cyc + 32'd1;
    assign w_expire  = (r_to != '0) && (w_run_nxt == r_to);

    // A start in the same cycle as the host request wins the ports.
    assign host_gnt = host_req && (r_state == S_IDLE) && !(start && !rst_n);

    assign inst     = r_inst;
    assign inst_vld = r_inst_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign status   = r_status;
    assign cyc_cnt  = r_cyc;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_inst     <= '0;
            r_inst_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_status   <= '0;
            r_cyc      <= '0;
            r_to       <= '0;
            r_run_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (start && r_state != S_IDLE)
                r_status[3] <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_inst        <= inst_cfg;
                        r_to          <= timeout_cfg;
                        r_status[2:0] <= 3'b000;
                        r_cyc         <= '0;
                        r_run_cnt     <= '0;
                        r_inst_vld    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        r_status[2] <= 1'b1;
                        r_inst_vld  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (inst_rdy) begin
                        r_inst_vld <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_run_cnt <= w_run_nxt;
                    r_cyc     <= w_cyc_nxt;
                    // Completion beats abort, abort beats timeout.
                    if (irq) begin
                        r_status[0] <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (abort) begin
                        r_status[2] <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_expire) begin
                        r_status[1] <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_job_seq.sv
// Directed bench for cim_job_seq: a job-level reference model checked every cycle,
// plus hand-computed expectations after each scenario.
module tb_cim_job_seq;

    localparam int TO_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     inst_cfg = '0;
    logic [TO_W-1:0] timeout_cfg = '0;
    logic            abort = 1'b0;
    logic [31:0]     inst;
    logic            inst_vld;
    logic            inst_rdy = 1'b0;
    logic            irq = 1'b0;
    logic            host_req = 1'b0;
    logic            host_gnt;
    logic            busy;
    logic            done;
    logic [3:0]      status;
    logic [31:0]     cyc_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    cim_job_seq #(.TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_cfg(inst_cfg),
        .timeout_cfg(timeout_cfg), .abort(abort), .inst(inst), .inst_vld(inst_vld),
        .inst_rdy(inst_rdy), .irq(irq), .host_req(host_req), .host_gnt(host_gnt),
        .busy(busy), .done(done), .status(status), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    // Job-level reference: a job is either waiting for its handshake, running,
    // or reporting its outcome for one cycle.
    bit          m_active, m_waiting, m_running, m_reporting;
    logic [31:0] m_inst;
    logic [3:0]  m_status;
    longint      m_runs, m_cyc, m_to;

    always @(posedge clk) begin
        if (rst_n) begin
            m_active = 0; m_waiting = 0; m_running = 0; m_reporting = 0;
            m_inst = '0; m_status = '0; m_runs = 0; m_cyc = 0; m_to = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_waiting = 1;
                m_inst = inst_cfg; m_to = timeout_cfg;
                m_status[2:0] = 3'b000; m_runs = 0; m_cyc = 0;
            end
        end else begin
            if (start) m_status[3] = 1'b1;
            if (m_reporting) begin
                m_reporting = 0; m_active = 0;
            end else if (m_waiting) begin
                if (abort) begin
                    m_waiting = 0; m_reporting = 1; m_status[2] = 1'b1;
                end else if (inst_rdy) begin
                    m_waiting = 0; m_running = 1;
                end
            end else if (m_running) begin
                if (m_runs < 65535) m_runs++;
                if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
                if (irq)                          m_status[0] = 1'b1;
                else if (abort)                   m_status[2] = 1'b1;
                else if (m_to != 0 && m_runs == m_to) m_status[1] = 1'b1;
                if (irq || abort || (m_to != 0 && m_runs == m_to)) begin
                    m_running = 0; m_reporting = 1;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("inst",     inst,             m_inst);
            cmp("inst_vld", 32'(inst_vld),    32'(m_waiting));
            cmp("busy",     32'(busy),        32'(m_active));
            cmp("done",     32'(done),        32'(m_reporting));
            cmp("status",   32'(status),      32'(m_status));
            cmp("cyc_cnt",  cyc_cnt,          m_cyc[31:0]);
            cmp("host_gnt", 32'(host_gnt),    32'(host_req && !m_active && !(start && !rst_n)));
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] ic, input logic [TO_W-1:0] to);
        inst_cfg = ic; timeout_cfg = to; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        inst_rdy = 1'b1;
        tick();
        inst_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL %s: job did not finish within %0d cycles", name, budget);
        end
    endtask

    int d0;

    initial begin
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        cmp("reset_status", 32'(status), 32'h0);
        cmp("reset_busy", 32'(busy), 32'h0);
        cmp("reset_inst", inst, 32'h0);
        rst_n = 1'b0;

        // Nominal job, host arbitration, stray irq in IDLE
        host_req = 1'b1; irq = 1'b1;
        tick();
        irq = 1'b0;
        cmp("gnt_idle", 32'(host_gnt), 32'h1);
        d0 = done_cnt;
        inst_cfg = 32'hf0f0_f0f0; timeout_cfg = '0; start = 1'b1;
        #1;
        cmp("gnt_on_start", 32'(host_gnt), 32'h0);
        tick();
        start = 1'b0;
        cmp("gnt_busy", 32'(host_gnt), 32'h0);
        tick();
        handshake();
        repeat (9) tick();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        wait_idle("nominal", 20);
        cmp("nom_inst", inst, 32'hf0f0_f0f0);
        cmp("nom_status", 32'(status), 32'h1);
        cmp("nom_cyc", cyc_cnt, 32'd10);
        cmp("nom_done_pulses", 32'(done_cnt - d0), 32'd1);
        host_req = 1'b0;

        // Timeout
        start_job(32'h0000_0011, 16'd5);
        handshake();
        wait_idle("timeout", 50);
        cmp("to_status", 32'(status), 32'h2);
        cmp("to_cyc", cyc_cnt, 32'd5);

        // Timeout disabled: stays running
        start_job(32'h0000_0022, 16'd0);
        handshake();
        repeat (1000) tick();
        cmp("noto_busy", 32'(busy), 32'h1);
        cmp("noto_cyc", cyc_cnt, 32'd1000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("noto_abort", 10);
        cmp("noto_status", 32'(status), 32'h4);
        cmp("noto_cyc_end", cyc_cnt, 32'd1001);

        // irq + abort on the expiry cycle
        start_job(32'h0000_0033, 16'd3);
        handshake();
        repeat (2) tick();
        irq = 1'b1; abort = 1'b1;
        tick();
        irq = 1'b0; abort = 1'b0;
        wait_idle("collide", 10);
        cmp("col_status", 32'(status), 32'h1);
        cmp("col_cyc", cyc_cnt, 32'd3);

        // Abort during ISSUE (irq there must be ignored)
        start_job(32'h0000_0044, 16'd0);
        abort = 1'b1; irq = 1'b1;
        tick();
        abort = 1'b0; irq = 1'b0;
        cmp("abi_vld", 32'(inst_vld), 32'h0);
        cmp("abi_done", 32'(done), 32'h1);
        wait_idle("abort_issue", 10);
        cmp("abi_status", 32'(status), 32'h4);
        cmp("abi_cyc", cyc_cnt, 32'd0);

        // start while running
        start_job(32'h0000_0055, 16'd0);
        handshake();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        wait_idle("busy_start", 10);
        cmp("bs_status", 32'(status), 32'h9);
        cmp("bs_cyc", cyc_cnt, 32'd7);
        cmp("bs_inst", inst, 32'h0000_0055);

        // Reset in the middle of RUN, then a fresh job
        d0 = done_cnt;
        start_job(32'h0000_0066, 16'd0);
        handshake();
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        cmp("rr_busy", 32'(busy), 32'h0);
        cmp("rr_status", 32'(status), 32'h0);
        cmp("rr_cyc", cyc_cnt, 32'h0);
        cmp("rr_inst", inst, 32'h0);
        tick();
        cmp("rr_no_done", 32'(done_cnt - d0), 32'd0);
        start_job(32'h1234_5678, 16'd0);
        handshake();
        tick();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        wait_idle("after_reset", 10);
        cmp("ar_status", 32'(status), 32'h1);
        cmp("ar_cyc", cyc_cnt, 32'd2);
        cmp("ar_inst", inst, 32'h1234_5678);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
